totient_seg_checker: RTL

TOTIENT_SEG_CHECKER -- requirements
Module: totient_seg_checker

---
 rtl/totient_seg_checker.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/totient_seg_checker.sv
// Seven-segment sample checker: decodes each strobed code and tracks it against a
// ping-pong walk over the totient table phi[0..15], with hunt/sync/lock acquisition.
module totient_seg_checker #(
  parameter int MISS_LIMIT = 3,
  parameter int ERR_W      = 8
) (
  input  logic             clk_0,
  input  logic             R,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  input  logic             D,
  input  logic             E,
  input  logic             F,
  input  logic             G,
  input  logic             en,
  output logic [3:0]       value,
  output logic             valid,
  output logic             code_err,
  output logic             mismatch,
  output logic             locked,
  output logic [3:0]       exp_index,
  output logic             dir,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int                MISS_W    = (MISS_LIMIT < 2) ? 1 : $clog2(MISS_LIMIT);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_LIMIT - 1);

  state_t             r_state;
  logic [3:0]         r_value;
  logic               r_valid;
  logic               r_code_err;
  logic               r_mismatch;
  logic               r_locked;
  logic [3:0]         r_exp_index;
  logic               r_dir;
  logic [ERR_W-1:0]   r_err_count;
  logic [MISS_W-1:0]  r_miss_cnt;

  logic [6:0] w_code;
  logic [3:0] w_dec_value;
  logic       w_dec_legal;
  logic [3:0] w_step_idx;
  logic       w_step_dir;
  logic [3:0] w_phi;
  logic       w_hit;

  assign w_code = {A, B, C, D, E, F, G};

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_dec_value = 4'd0;
    w_dec_legal = 1'b1;
    unique case (w_code)
      7'b0110000: w_dec_value = 4'd1;
      7'b1101101: w_dec_value = 4'd2;
      7'b0110011: w_dec_value = 4'd4;
      7'b1011111: w_dec_value = 4'd6;
      7'b1111111: w_dec_value = 4'd8;
      7'b1110111: w_dec_value = 4'd10;
      7'b1001110: w_dec_value = 4'd12;
      7'b0000000: w_dec_value = 4'd0;
      default:    w_dec_legal = 1'b0;
    endcase
  end

  // Model walks 0..15 and bounces, holding the end index for one step at each turn.
  always_comb begin
    w_step_idx = r_exp_index;
    w_step_dir = r_dir;
    if (!r_dir) begin
      if (r_exp_index == 4'd15) w_step_dir = 1'b1;
      else                      w_step_idx = r_exp_index + 4'd1;
    end else begin
      if (r_exp_index == 4'd0)  w_step_dir = 1'b0;
      else                      w_step_idx = r_exp_index - 4'd1;
    end
  end

  always_comb begin
    w_phi = 4'd0;
    unique case (w_step_idx)
      4'd0:  w_phi = 4'd1;
      4'd1:  w_phi = 4'd1;
      4'd2:  w_phi = 4'd2;
      4'd3:  w_phi = 4'd2;
      4'd4:  w_phi = 4'd4;
      4'd5:  w_phi = 4'd2;
      4'd6:  w_phi = 4'd6;
      4'd7:  w_phi = 4'd4;
      4'd8:  w_phi = 4'd6;
      4'd9:  w_phi = 4'd4;
      4'd10: w_phi = 4'd10;
      4'd11: w_phi = 4'd4;
      4'd12: w_phi = 4'd12;
      4'd13: w_phi = 4'd6;
      4'd14: w_phi = 4'd8;
      4'd15: w_phi = 4'd8;
      default: w_phi = 4'd0;
    endcase
  end

  // An illegal code decodes to 0, which phi never holds, but legality is checked explicitly.
  assign w_hit = w_dec_legal && (w_dec_value == w_phi);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_0 or negedge R) begin
    if (!R) begin
      r_state     <= HUNT;
      r_value     <= 4'd0;
      r_valid     <= 1'b0;
      r_code_err  <= 1'b0;
      r_mismatch  <= 1'b0;
      r_locked    <= 1'b0;
      r_exp_index <= 4'd0;
      r_dir       <= 1'b0;
      r_err_count <= '0;
      r_miss_cnt  <= '0;
    end else begin
      r_valid    <= en;
      r_code_err <= en & ~w_dec_legal;
      r_mismatch <= 1'b0;
      if (en) begin
        r_value <= w_dec_value;
        unique case (r_state)
          HUNT: begin
            if (w_dec_legal && w_dec_value == 4'd12) r_state <= SYNC;
          end
          SYNC: begin
            if (w_dec_legal && w_dec_value == 4'd6) begin
              r_state     <= LOCKED;
              r_locked    <= 1'b1;
              r_exp_index <= 4'd13;
              r_dir       <= 1'b0;
              r_miss_cnt  <= '0;
            end else if (w_dec_legal && w_dec_value == 4'd4) begin
              r_state     <= LOCKED;
              r_locked    <= 1'b1;
              r_exp_index <= 4'd11;
              r_dir       <= 1'b1;
              r_miss_cnt  <= '0;
            end else if (!(w_dec_legal && w_dec_value == 4'd12)) begin
              r_state <= HUNT;
            end
          end
          LOCKED: begin
            r_exp_index <= w_step_idx;
            r_dir       <= w_step_dir;
            if (w_hit) begin
              r_miss_cnt <= '0;
            end else begin
              r_mismatch <= 1'b1;
              if (r_err_count != {ERR_W{1'b1}}) r_err_count <= r_err_count + 1'b1;
              if (r_miss_cnt == MISS_LAST) begin
                r_state    <= HUNT;
                r_locked   <= 1'b0;
                r_miss_cnt <= '0;
              end else begin
                r_miss_cnt <= r_miss_cnt + 1'b1;
              end
            end
          end
          default: begin
            r_state  <= HUNT;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign value     = r_value;
  assign valid     = r_valid;
  assign code_err  = r_code_err;
  assign mismatch  = r_mismatch;
  assign locked    = r_locked;
  assign exp_index = r_exp_index;
  assign dir       = r_dir;
  assign err_count = r_err_count;

endmodule
